// File: rtl/lane_rot_pkg.sv
// Shared types and the direction-to-left-amount helper for the lane rotator family.
package lane_rot_pkg;

   localparam int unsigned DefLanes = 4;
   localparam int unsigned DefLaneW = 8;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_e;

   typedef enum logic {
      MODE_ROT   = 1'b0,
      MODE_SHIFT = 1'b1
   } mode_e;

   // Right by s is left by (lanes - s) mod lanes; lanes is a power of two.
   function automatic int unsigned eff_left_amt(input int unsigned shamt, input dir_e dir,
                                                input int unsigned lanes);
      if (dir == DIR_RIGHT) return (lanes - shamt) & (lanes - 1);
      return shamt & (lanes - 1);
   endfunction

endpackage

// File: rtl/lane_rotator_pipe_if.sv
// Request/result handshake bundle for lane_rotator_pipe.
interface lane_rotator_pipe_if #(
   parameter int unsigned LANES  = lane_rot_pkg::DefLanes,
   parameter int unsigned LANE_W = lane_rot_pkg::DefLaneW
) ();
   import lane_rot_pkg::*;

   localparam int unsigned SH_W = $clog2(LANES);

   logic                    in_valid;
   logic                    in_ready;
   dir_e                    in_dir;
   mode_e                   in_mode;
   logic [SH_W-1:0]         in_shamt;
   logic [LANES*LANE_W-1:0] in_data;
   logic [LANES-1:0]        in_mask;
   logic                    out_valid;
   logic                    out_ready;
   logic [LANES*LANE_W-1:0] out_data;
   logic [LANES-1:0]        out_mask;

   modport master (
      output in_valid, in_dir, in_mode, in_shamt, in_data, in_mask, out_ready,
      input  in_ready, out_valid, out_data, out_mask
   );

   modport slave (
      input  in_valid, in_dir, in_mode, in_shamt, in_data, in_mask, out_ready,
      output in_ready, out_valid, out_data, out_mask
   );

endinterface

// File: rtl/lane_perm_comb.sv
// Combinational lane permuter: rotate or zero-fill shift by an effective left amount k.
module lane_perm_comb
   import lane_rot_pkg::*;
#(
   parameter  int unsigned LANES  = DefLanes,
   parameter  int unsigned LANE_W = DefLaneW,
   localparam int unsigned SH_W   = $clog2(LANES)
) (
   input  logic [SH_W-1:0]         k,
   input  logic                    right,
   input  mode_e                   mode,
   input  logic [LANES*LANE_W-1:0] data,
   input  logic [LANES-1:0]        mask,
   output logic [LANES*LANE_W-1:0] perm_data,
   output logic [LANES-1:0]        perm_mask
);

   logic [SH_W-1:0] lane_idx [LANES];
   logic [SH_W-1:0] src_idx  [LANES];
   logic            keep     [LANES];

   // Every output lane j sources lane (j - k) mod LANES; shifts just blank the wrapped lanes.
   // For a right shift, k = LANES - s, so lanes j < k are the surviving ones (k = 0 keeps all).
   always_comb begin
      perm_data = '0;
      perm_mask = '0;
      for (int j = 0; j < LANES; j++) begin
         lane_idx[j] = SH_W'(j);
         src_idx[j]  = lane_idx[j] - k;
         if (mode == MODE_ROT) keep[j] = 1'b1;
         else if (right)       keep[j] = (k == '0) || (lane_idx[j] < k);
         else                  keep[j] = (lane_idx[j] >= k);
         if (keep[j]) begin
            perm_data[j*LANE_W +: LANE_W] = data[src_idx[j]*LANE_W +: LANE_W];
            perm_mask[j]                  = mask[src_idx[j]];
         end
      end
   end

endmodule

// File: rtl/lane_rotator_pipe.sv
// Two-stage valid/ready lane rotator: S1 normalises the request, S2 registers the permuted lanes.
module lane_rotator_pipe
   import lane_rot_pkg::*;
#(
   parameter  int unsigned LANES  = DefLanes,
   parameter  int unsigned LANE_W = DefLaneW,
   localparam int unsigned SH_W   = $clog2(LANES)
) (
   input logic                clk,
   input logic                rst,
   lane_rotator_pipe_if.slave bus
);

   localparam int unsigned DW = LANES * LANE_W;

   logic            s1_valid_q, s2_valid_q, s1_right_q;
   logic [SH_W-1:0] s1_k_q;
   mode_e           s1_mode_q;
   logic [DW-1:0]   s1_data_q, s2_data_q, perm_data;
   logic [LANES-1:0] s1_mask_q, s2_mask_q, perm_mask;
   logic            in_rdy, s1_load, s2_load;

   always_comb begin
      in_rdy  = !s1_valid_q || !s2_valid_q || bus.out_ready;
      s2_load = s1_valid_q && (!s2_valid_q || bus.out_ready);
      s1_load = bus.in_valid && in_rdy;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s1_right_q <= 1'b0;
         s1_k_q     <= '0;
         s1_mode_q  <= MODE_ROT;
         s1_data_q  <= '0;
         s1_mask_q  <= '0;
         s2_data_q  <= '0;
         s2_mask_q  <= '0;
      end else begin
         if (s1_load)      s1_valid_q <= 1'b1;
         else if (s2_load) s1_valid_q <= 1'b0;

         if (s2_load)            s2_valid_q <= 1'b1;
         else if (bus.out_ready) s2_valid_q <= 1'b0;

         if (s1_load) begin
            s1_k_q     <= SH_W'(eff_left_amt(32'(bus.in_shamt), bus.in_dir, LANES));
            s1_right_q <= (bus.in_dir == DIR_RIGHT);
            s1_mode_q  <= bus.in_mode;
            s1_data_q  <= bus.in_data;
            s1_mask_q  <= bus.in_mask;
         end

         if (s2_load) begin
            s2_data_q <= perm_data;
            s2_mask_q <= perm_mask;
         end
      end
   end

   lane_perm_comb #(
      .LANES (LANES),
      .LANE_W(LANE_W)
   ) u_perm (
      .k        (s1_k_q),
      .right    (s1_right_q),
      .mode     (s1_mode_q),
      .data     (s1_data_q),
      .mask     (s1_mask_q),
      .perm_data(perm_data),
      .perm_mask(perm_mask)
   );

   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = s2_valid_q;
   assign bus.out_data  = s2_data_q;
   assign bus.out_mask  = s2_mask_q;

endmodule

// File: tb/tb_lane_rotator_pipe.sv
// Scoreboard bench: directed 4x8 cases plus a randomised 8x4 run with random backpressure.
module tb_lane_rotator_pipe;
   import lane_rot_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   lane_rotator_pipe_if #(.LANES(4), .LANE_W(8)) b4 ();
   lane_rotator_pipe_if #(.LANES(8), .LANE_W(4)) b8 ();

   lane_rotator_pipe #(.LANES(4), .LANE_W(8)) dut4 (.clk(clk), .rst(rst), .bus(b4));
   lane_rotator_pipe #(.LANES(8), .LANE_W(4)) dut8 (.clk(clk), .rst(rst), .bus(b8));

   int errors = 0;
   int checks = 0;
   logic [39:0] q4[$];
   logic [39:0] q8[$];
   int acc8 = 0;
   int emit8 = 0;
   bit drv_done = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Independent model: rotate via the package helper, shifts straight from lane indices.
   function automatic logic [39:0] ref_perm(input int unsigned lanes, input int unsigned lw,
                                            input logic [31:0] d, input logic [7:0] m,
                                            input dir_e dir, input mode_e mode,
                                            input int unsigned s);
      logic [31:0] od;
      logic [7:0]  om;
      int unsigned k, dst;
      od = '0;
      om = '0;
      k  = eff_left_amt(s, dir, lanes);
      for (int unsigned i = 0; i < lanes; i++) begin
         if (mode == MODE_ROT) begin
            dst = (i + k) % lanes;
            for (int unsigned b = 0; b < lw; b++) od[dst*lw+b] = d[i*lw+b];
            om[dst] = m[i];
         end else if (dir == DIR_LEFT && i >= s) begin
            for (int unsigned b = 0; b < lw; b++) od[i*lw+b] = d[(i-s)*lw+b];
            om[i] = m[i-s];
         end else if (dir == DIR_RIGHT && i + s < lanes) begin
            for (int unsigned b = 0; b < lw; b++) od[i*lw+b] = d[(i+s)*lw+b];
            om[i] = m[i+s];
         end
      end
      return {om, od};
   endfunction

   task automatic drive4(input logic [31:0] d, input logic [3:0] m, input dir_e dir,
                         input mode_e mode, input int unsigned s, input logic [35:0] exp);
      b4.in_valid = 1'b1;
      b4.in_data  = d;
      b4.in_mask  = m;
      b4.in_dir   = dir;
      b4.in_mode  = mode;
      b4.in_shamt = 2'(s);
      q4.push_back({4'b0, exp});
   endtask

   task automatic send4(input logic [31:0] d, input logic [3:0] m, input dir_e dir,
                        input mode_e mode, input int unsigned s, input logic [35:0] exp);
      bit ok = 1'b0;
      drive4(d, m, dir, mode, s, exp);
      for (int t = 0; t < 100 && !ok; t++) begin
         @(negedge clk);
         ok = b4.in_ready;
         tick();
      end
      if (!ok) begin
         void'(q4.pop_back());
         check("accept4_timeout", 0, 1);
      end
   endtask

   task automatic send8(input logic [31:0] d, input logic [7:0] m, input dir_e dir,
                        input mode_e mode, input int unsigned s);
      bit ok = 1'b0;
      b8.in_valid = 1'b1;
      b8.in_data  = d;
      b8.in_mask  = m;
      b8.in_dir   = dir;
      b8.in_mode  = mode;
      b8.in_shamt = 3'(s);
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         ok = b8.in_ready;
         tick();
      end
      if (ok) begin
         q8.push_back(ref_perm(8, 4, d, m, dir, mode, s));
         acc8++;
      end else begin
         check("accept8_timeout", 0, 1);
      end
   endtask

   // Output monitors: pop on every transfer, and require held outputs across a stall.
   bit          stall4 = 1'b0, stall8 = 1'b0;
   logic [39:0] held4, held8;

   always @(negedge clk) begin
      if (rst) begin
         stall4 = 1'b0;
         stall8 = 1'b0;
      end else begin
         if (stall4 && b4.out_valid) check("hold4", {b4.out_mask, b4.out_data}, held4);
         if (b4.out_valid && b4.out_ready) begin
            if (q4.size() == 0) check("spurious4", 1, 0);
            else check("data4", {b4.out_mask, b4.out_data}, q4.pop_front());
         end
         stall4 = b4.out_valid && !b4.out_ready;
         held4  = {4'b0, b4.out_mask, b4.out_data};

         if (stall8 && b8.out_valid) check("hold8", {b8.out_mask, b8.out_data}, held8);
         if (b8.out_valid && b8.out_ready) begin
            emit8++;
            if (q8.size() == 0) check("spurious8", 1, 0);
            else check("data8", {b8.out_mask, b8.out_data}, q8.pop_front());
         end
         stall8 = b8.out_valid && !b8.out_ready;
         held8  = {b8.out_mask, b8.out_data};
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      b4.in_valid = 1'b0; b4.in_data = '0; b4.in_mask = '0; b4.in_dir = DIR_LEFT;
      b4.in_mode = MODE_ROT; b4.in_shamt = '0; b4.out_ready = 1'b1;
      b8.in_valid = 1'b0; b8.in_data = '0; b8.in_mask = '0; b8.in_dir = DIR_LEFT;
      b8.in_mode = MODE_ROT; b8.in_shamt = '0; b8.out_ready = 1'b1;

      // Reset state
      rst = 1'b1;
      tick();
      tick();
      @(negedge clk);
      check("rst_ov4", b4.out_valid, 0);
      check("rst_out4", {b4.out_mask, b4.out_data}, 0);
      check("rst_ov8", b8.out_valid, 0);
      check("rst_out8", {b8.out_mask, b8.out_data}, 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst_rdy4", b4.in_ready, 1);
      check("rst_rdy8", b8.in_ready, 1);
      tick();

      // Latency: accept edge, one cycle in S1, valid on the second cycle
      send4(32'h44332211, 4'b0011, DIR_LEFT, MODE_ROT, 1, {4'b0110, 32'h33221144});
      b4.in_valid = 1'b0;
      @(negedge clk);
      check("lat_n1", b4.out_valid, 0);
      tick();
      @(negedge clk);
      check("lat_n2", b4.out_valid, 1);
      tick();

      // Directed patterns, back to back
      send4(32'h44332211, 4'b0011, DIR_RIGHT, MODE_ROT, 1, {4'b1001, 32'h11443322});
      send4(32'h44332211, 4'b0011, DIR_LEFT, MODE_ROT, 0, {4'b0011, 32'h44332211});
      send4(32'h44332211, 4'b0011, DIR_RIGHT, MODE_ROT, 0, {4'b0011, 32'h44332211});
      send4(32'h44332211, 4'b0011, DIR_LEFT, MODE_ROT, 3, {4'b1001, 32'h11443322});
      send4(32'h44332211, 4'b1111, DIR_LEFT, MODE_SHIFT, 1, {4'b1110, 32'h33221100});
      send4(32'h44332211, 4'b1111, DIR_RIGHT, MODE_SHIFT, 3, {4'b0001, 32'h00000044});
      send4(32'h44332211, 4'b1111, DIR_LEFT, MODE_SHIFT, 3, {4'b1000, 32'h11000000});
      send4(32'h44332211, 4'b0101, DIR_RIGHT, MODE_SHIFT, 0, {4'b0101, 32'h44332211});
      b4.in_valid = 1'b0;
      repeat (4) tick();
      check("drain4", q4.size(), 0);

      // Backpressure: A and B buffered, C waits, then all drain in order
      b4.out_ready = 1'b0;
      drive4(32'h44332211, 4'b0011, DIR_LEFT, MODE_ROT, 1, {4'b0110, 32'h33221144});
      @(negedge clk);
      check("bp_rdy_a", b4.in_ready, 1);
      tick();
      drive4(32'hA1B2C3D4, 4'b1111, DIR_LEFT, MODE_SHIFT, 0, {4'b1111, 32'hA1B2C3D4});
      @(negedge clk);
      check("bp_rdy_b", b4.in_ready, 1);
      tick();
      drive4(32'h44332211, 4'b1111, DIR_RIGHT, MODE_SHIFT, 1, {4'b0111, 32'h00443322});
      @(negedge clk);
      check("bp_rdy_c0", b4.in_ready, 0);
      check("bp_ov_stall", b4.out_valid, 1);
      tick();
      @(negedge clk);
      check("bp_rdy_c1", b4.in_ready, 0);
      tick();
      tick();
      b4.out_ready = 1'b1;
      @(negedge clk);
      check("bp_rdy_rel", b4.in_ready, 1);
      check("bp_out0", b4.out_valid, 1);
      tick();
      b4.in_valid = 1'b0;
      @(negedge clk);
      check("bp_out1", b4.out_valid, 1);
      tick();
      @(negedge clk);
      check("bp_out2", b4.out_valid, 1);
      tick();
      @(negedge clk);
      check("bp_out3", b4.out_valid, 0);
      check("bp_drain", q4.size(), 0);
      tick();

      // Reset with both stages full; in_* activity during reset must be ignored
      b4.out_ready = 1'b0;
      drive4(32'h01020304, 4'b1111, DIR_LEFT, MODE_ROT, 2, 36'h0);
      tick();
      drive4(32'h05060708, 4'b1111, DIR_RIGHT, MODE_ROT, 2, 36'h0);
      tick();
      b4.in_valid = 1'b0;
      @(negedge clk);
      check("mf_full_ov", b4.out_valid, 1);
      check("mf_full_rdy", b4.in_ready, 0);
      tick();
      rst = 1'b1;
      q4.delete();
      b4.in_valid = 1'b1;
      b4.in_data  = 32'hDEADBEEF;
      tick();
      rst = 1'b0;
      b4.in_valid = 1'b0;
      @(negedge clk);
      check("mf_ov", b4.out_valid, 0);
      check("mf_out", {b4.out_mask, b4.out_data}, 0);
      check("mf_rdy", b4.in_ready, 1);
      tick();
      b4.out_ready = 1'b1;
      @(negedge clk);
      check("mf_no_stale1", b4.out_valid, 0);
      tick();
      @(negedge clk);
      check("mf_no_stale2", b4.out_valid, 0);
      tick();

      // Randomised 8x4 traffic with random out_ready
      fork
         begin
            for (int n = 0; n < 1000; n++) begin
               if ($urandom_range(0, 3) == 0) begin
                  b8.in_valid = 1'b0;
                  tick();
               end
               send8($urandom, 8'($urandom), dir_e'($urandom_range(0, 1)),
                     mode_e'($urandom_range(0, 1)), $urandom_range(0, 7));
            end
            b8.in_valid = 1'b0;
            drv_done = 1'b1;
         end
         begin
            while (!drv_done) begin
               b8.out_ready = 1'($urandom_range(0, 1));
               tick();
            end
         end
      join
      b8.out_ready = 1'b1;
      for (int t = 0; t < 20 && q8.size() != 0; t++) tick();
      tick();
      check("rand_accepted", acc8, 1000);
      check("rand_drain", q8.size(), 0);
      check("rand_conserve", emit8, acc8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lane_rotator_pipe.md
Name: lane_rotator_pipe

Overview:
- Parametrised, pipelined lane rotator/shifter for the composed-RAM sub-handlers.
- Moves LANES lanes of LANE_W bits, plus a per-lane byte-enable mask, left or right by a lane count.
- Mode selects rotate or zero-fill shift.
- Sits between the bus-side address/data path and the narrow sub-RAM banks, replacing fixed 4-bit combinational rotators with a 2-stage valid/ready pipeline.

Parameters:
- LANES, 4, number of lanes; power of two, >= 2
- LANE_W, 8, bits per lane
- SH_W, $clog2(LANES), shift-amount width (derived, not overridden)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  block accepts a request this cycle
- in_dir  input  1  0 = left (towards higher lane index), 1 = right
- in_mode  input  1  0 = rotate, 1 = logical shift with zero fill
- in_shamt  input  SH_W  lane count
- in_data  input  LANES*LANE_W  lane i = in_data[i*LANE_W +: LANE_W]
- in_mask  input  LANES  per-lane enable; bit i belongs to lane i
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_data  output  LANES*LANE_W  transformed data
- out_mask  output  LANES  transformed mask

Behaviour:
- Transfer occurs when valid && ready on a side.
- Latency: a request accepted in cycle N appears on out_valid in cycle N+2 if out_ready has been high.
- Throughput: 1 per cycle while out_ready is high.
- Stage 1 (S1) registers data, mask and mode, and converts the request to an effective left amount k:
  - dir=0: k = shamt
  - dir=1: k = (LANES - shamt) mod LANES
  - also registers a 1-bit right flag for the zero-fill side.
- Stage 2 (S2) computes and registers the result.
  - Rotate: out lane (i+k) mod LANES = in lane i; the mask moves identically.
  - Shift left by s: out lane j = in lane j-s for j >= s, else 0.
  - Shift right by s: out lane j = in lane j+s for j+s < LANES, else 0.
  - Vacated mask bits are 0.
  - shamt = 0 passes data through unchanged in both modes and directions.
- Arithmetic: all lane-index math is modulo LANES in SH_W bits; no lane index out of range is ever formed.
- Flow control:
  - S2 loads when S1 is valid and (S2 empty or out_ready).
  - S1 loads when in_valid and (S1 empty or S1 moving to S2).
  - in_ready = !s1_valid || (!s2_valid || out_ready).
  - in_ready depends only on registered state and out_ready, never on in_valid.
- Backpressure: with out_ready low, S2 holds, S1 fills, and then in_ready = 0. At most 2 results are buffered; none is dropped or duplicated.
- Output stability: while out_valid && !out_ready, out_data and out_mask are held constant.
- Simultaneous events: accept-into-S1 and drain-from-S2 in the same cycle is legal and keeps full throughput.
- Reset:
  - Next edge with rst=1: s1_valid = 0, s2_valid = 0, out_valid = 0, out_data = 0, out_mask = 0; in_ready = 1 one cycle after rst deasserts.
  - Reset mid-operation discards in-flight requests without emitting them.
  - in_* are ignored while rst = 1.
- No X propagation: data registers load only on their stage enable.

Decomposition:
- Shared package lane_rot_pkg:
  - typedef dir_e {DIR_LEFT, DIR_RIGHT}
  - typedef mode_e {MODE_ROT, MODE_SHIFT}
  - function eff_left_amt(shamt, dir) used by S1 and by the bench model.
- One sub-module lane_perm_comb: purely combinational. Inputs are k, right flag, mode, data and mask; outputs are the permuted data and mask. It is instantiated once in S2 and is reusable by other handlers. The top holds the pipeline registers and handshake only.

Test Plan:
- LANES=4, LANE_W=8, data 0x44332211, mask 4'b0011, rotate left 1 -> out_data 0x33221144, out_mask 4'b0110, out_valid exactly 2 cycles after accept.
- Same data, rotate right 1 -> 0x11443322, mask 4'b1001; rotate left 0 and right 0 -> 0x44332211, mask 4'b0011.
- Shift left 1 on data 0x44332211, mask 4'b1111 -> 0x33221100, 4'b1110. Shift right 3 -> 0x00000044, 4'b0001.
- Backpressure: issue A, B, C back-to-back with out_ready=0 for 4 cycles:
  - in_ready drops after A and B are held; C waits.
  - Then out_ready=1 -> A, B, C emerge in order on consecutive cycles, out_data stable while stalled.
- Reset mid-flight: rst=1 for 1 cycle while S1 and S2 are valid -> next cycle out_valid=0, out_data=0, no stale output ever appears, in_ready=1 after release.
- LANES=8, LANE_W=4: random dir/mode/shamt, 1000 transfers with random out_ready. Compare against the package-function reference model and check count conservation (accepted == emitted).
